// File: rtl/vending_machine.sv
// Card-operated vending controller: two-digit keypad selection, cost display,
// payment wait, vend and delivery-door supervision over NUM_ITEMS stocked slots.
module vending_machine #(
  parameter int NUM_ITEMS = 20,
  parameter int CAPACITY  = 10,
  parameter int TIMEOUT   = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RELOAD,
  input  logic       CARD_IN,
  input  logic [3:0] ITEM_CODE,
  input  logic       KEY_PRESS,
  input  logic       VALID_TRAN,
  input  logic       DOOR_OPEN,
  output logic       VEND,
  output logic       INVALID_SEL,
  output logic [2:0] COST,
  output logic       FAILED_TRAN
);

  localparam int CNT_W  = $clog2(CAPACITY + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int CODE_W = $clog2(NUM_ITEMS);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_D1, S_GET_D2, S_CHECK, S_WAIT_PAY, S_WAIT_DOOR, S_DOOR_OPENED
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [3:0]        r_d1, w_d1_nxt, r_d2, w_d2_nxt;
  logic [CODE_W-1:0] r_code, w_code_nxt;
  logic              r_key_prev;
  logic              r_vend, w_vend_nxt, r_inv, w_inv_nxt, r_fail, w_fail_nxt;
  logic [2:0]        r_cost, w_cost_nxt;
  logic [CNT_W-1:0]  r_cnt [NUM_ITEMS];
  logic [CNT_W-1:0]  w_slot_cnt;
  logic [7:0]        w_code;
  logic              w_key_edge, w_tmo, w_sel_ok, w_reload, w_dec;

  function automatic logic [2:0] price(input logic [7:0] code);
    if (code <= 8'd3)       price = 3'd1;
    else if (code <= 8'd7)  price = 3'd2;
    else if (code <= 8'd11) price = 3'd3;
    else if (code <= 8'd15) price = 3'd4;
    else if (code <= 8'd17) price = 3'd5;
    else                    price = 3'd6;
  endfunction

  assign w_key_edge = KEY_PRESS & ~r_key_prev;
  assign w_tmo      = (r_tmr == TMR_W'(TIMEOUT - 1));
  assign w_code     = ({4'd0, r_d1} * 8'd10) + {4'd0, r_d2};

  // Stock count of the slot addressed by the entered digits (0 if out of range)
  always_comb begin
    w_slot_cnt = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_slot_cnt = (w_code == 8'(i)) ? r_cnt[i] : w_slot_cnt;
    end
  end

  assign w_sel_ok = (r_d1 <= 4'd1) && (r_d2 <= 4'd9) &&
                    (w_code < 8'(NUM_ITEMS)) && (w_slot_cnt != '0);

  // Next-state and next-output decode; the timer restarts whenever it is not advanced
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = '0;
    w_d1_nxt    = r_d1;
    w_d2_nxt    = r_d2;
    w_code_nxt  = r_code;
    w_vend_nxt  = r_vend;
    w_cost_nxt  = r_cost;
    w_inv_nxt   = 1'b0;
    w_fail_nxt  = 1'b0;
    w_reload    = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RELOAD)       w_reload    = 1'b1;
        else if (CARD_IN) w_state_nxt = S_GET_D1;
        else              w_state_nxt = S_IDLE;
      end
      S_GET_D1: begin
        if (w_key_edge) begin
          w_d1_nxt    = ITEM_CODE;
          w_state_nxt = S_GET_D2;
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_GET_D2: begin
        if (w_key_edge) begin
          w_d2_nxt    = ITEM_CODE;
          w_state_nxt = S_CHECK;
        end else if (w_tmo) begin
          w_inv_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_CHECK: begin
        if (w_sel_ok) begin
          w_cost_nxt  = price(w_code);
          w_code_nxt  = w_code[CODE_W-1:0];
          w_state_nxt = S_WAIT_PAY;
        end else begin
          w_inv_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_PAY: begin
        if (VALID_TRAN) begin
          w_vend_nxt  = 1'b1;
          w_dec       = 1'b1;
          w_state_nxt = S_WAIT_DOOR;
        end else if (w_tmo) begin
          w_fail_nxt  = 1'b1;
          w_cost_nxt  = 3'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_WAIT_DOOR: begin
        if (DOOR_OPEN) begin
          w_state_nxt = S_DOOR_OPENED;
        end else if (w_tmo) begin
          w_vend_nxt  = 1'b0;
          w_cost_nxt  = 3'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_DOOR_OPENED: begin
        if (!DOOR_OPEN) begin
          w_vend_nxt  = 1'b0;
          w_cost_nxt  = 3'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DOOR_OPENED;
        end
      end
      default: begin
        w_vend_nxt  = 1'b0;
        w_cost_nxt  = 3'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, timer, digits and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_d1       <= 4'd0;
      r_d2       <= 4'd0;
      r_code     <= '0;
      r_key_prev <= 1'b0;
      r_vend     <= 1'b0;
      r_inv      <= 1'b0;
      r_fail     <= 1'b0;
      r_cost     <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_d1       <= w_d1_nxt;
      r_d2       <= w_d2_nxt;
      r_code     <= w_code_nxt;
      r_key_prev <= KEY_PRESS;
      r_vend     <= w_vend_nxt;
      r_inv      <= w_inv_nxt;
      r_fail     <= w_fail_nxt;
      r_cost     <= w_cost_nxt;
    end
  end

  // Slot stock: reset empties, reload refills, a vend removes one unit (never below 0)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_ITEMS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (w_reload)
          r_cnt[i] <= CNT_W'(CAPACITY);
        else if (w_dec && (r_code == CODE_W'(i)) && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - 1'b1;
        else
          r_cnt[i] <= r_cnt[i];
      end
    end
  end

  assign VEND        = r_vend;
  assign INVALID_SEL = r_inv;
  assign FAILED_TRAN = r_fail;
  assign COST        = r_cost;

endmodule

// File: tb/tb_vending_machine.sv
// Directed testbench for vending_machine: hand-computed expectations for
// vend, door timeout, payment timeout, empty/invalid selections and card-only timeout.
module tb_vending_machine;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RELOAD = 1'b0, CARD_IN = 1'b0, KEY_PRESS = 1'b0;
  logic       VALID_TRAN = 1'b0, DOOR_OPEN = 1'b0;
  logic [3:0] ITEM_CODE = 4'd0;
  logic       VEND, INVALID_SEL, FAILED_TRAN;
  logic [2:0] COST;

  int n_cmp = 0;
  int n_bad = 0;

  vending_machine dut (
    .CLK(CLK), .RST(RST), .RELOAD(RELOAD), .CARD_IN(CARD_IN),
    .ITEM_CODE(ITEM_CODE), .KEY_PRESS(KEY_PRESS), .VALID_TRAN(VALID_TRAN),
    .DOOR_OPEN(DOOR_OPEN), .VEND(VEND), .INVALID_SEL(INVALID_SEL),
    .COST(COST), .FAILED_TRAN(FAILED_TRAN)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] d);
    ITEM_CODE = d;
    KEY_PRESS = 1'b1;
    step(1);
    KEY_PRESS = 1'b0;
    step(1);
  endtask

  task automatic reload();
    RELOAD = 1'b1;
    step(1);
    RELOAD = 1'b0;
  endtask

  task automatic card();
    CARD_IN = 1'b1;
    step(1);
    CARD_IN = 1'b0;
  endtask

  task automatic select(input logic [3:0] a, input logic [3:0] b);
    card();
    press(a);
    press(b);
  endtask

  initial begin
    int n;
    logic seen;

    step(2);
    check_eq("rst_vend", VEND, 0);
    check_eq("rst_cost", COST, 0);
    check_eq("rst_inv", INVALID_SEL, 0);
    check_eq("rst_fail", FAILED_TRAN, 0);
    check_eq("rst_slot16", dut.r_cnt[16], 0);
    RST = 1'b1;
    step(1);

    // Full vend with door opened and closed
    reload();
    check_eq("reload_slot16", dut.r_cnt[16], 10);
    select(4'd1, 4'd6);
    check_eq("t1_cost", COST, 5);
    check_eq("t1_vend_pre", VEND, 0);
    VALID_TRAN = 1'b1;
    step(1);
    VALID_TRAN = 1'b0;
    check_eq("t1_vend", VEND, 1);
    check_eq("t1_slot16", dut.r_cnt[16], 9);
    DOOR_OPEN = 1'b1;
    step(1);
    check_eq("t1_vend_open", VEND, 1);
    DOOR_OPEN = 1'b0;
    step(1);
    check_eq("t1_vend_done", VEND, 0);
    check_eq("t1_cost_done", COST, 0);

    // Door never opened: VEND high for TIMEOUT cycles
    select(4'd1, 4'd6);
    VALID_TRAN = 1'b1;
    step(1);
    VALID_TRAN = 1'b0;
    n = 0;
    while (VEND && n < 20) begin step(1); n++; end
    check_eq("t2_vend_cycles", n, 5);
    check_eq("t2_cost", COST, 0);
    check_eq("t2_slot16", dut.r_cnt[16], 8);

    // Payment never approved; RELOAD outside IDLE must be ignored
    select(4'd1, 4'd6);
    RELOAD = 1'b1;
    n = 0;
    while (COST == 3'd5 && n < 20) begin step(1); RELOAD = 1'b0; n++; end
    check_eq("t3_cost_cycles", n, 5);
    check_eq("t3_fail_pulse", FAILED_TRAN, 1);
    check_eq("t3_inv_quiet", INVALID_SEL, 0);
    step(1);
    check_eq("t3_fail_end", FAILED_TRAN, 0);
    check_eq("t3_slot16", dut.r_cnt[16], 8);

    // Reset mid-idle empties the machine; selection then rejected
    RST = 1'b0;
    #1;
    check_eq("t4_rst_slot16", dut.r_cnt[16], 0);
    step(1);
    RST = 1'b1;
    step(1);
    select(4'd1, 4'd6);
    check_eq("t4_inv", INVALID_SEL, 1);
    check_eq("t4_vend", VEND, 0);
    check_eq("t4_cost", COST, 0);
    step(1);
    check_eq("t4_inv_end", INVALID_SEL, 0);

    // Out-of-range digits and boundary codes
    reload();
    select(4'd2, 4'd6);
    check_eq("t5_code26_inv", INVALID_SEL, 1);
    step(1);
    select(4'd1, 4'd10);
    check_eq("t5_d2_10_inv", INVALID_SEL, 1);
    step(1);
    select(4'd1, 4'd9);
    check_eq("t5_code19_cost", COST, 6);
    check_eq("t5_code19_inv", INVALID_SEL, 0);
    step(6);
    check_eq("t5_code19_cleared", COST, 0);
    select(4'd0, 4'd0);
    check_eq("t5_code0_cost", COST, 1);
    step(6);
    select(4'd0, 4'd9);
    check_eq("t5_code9_cost", COST, 3);
    step(6);

    // Second digit never entered
    card();
    press(4'd2);
    n = 0;
    while (!INVALID_SEL && n < 10) begin step(1); n++; end
    check_eq("t5_d2_timeout", n, 4);
    check_eq("t5_d2_timeout_inv", INVALID_SEL, 1);
    step(1);
    check_eq("t5_d2_timeout_end", INVALID_SEL, 0);

    // Card held, no keys: silent timeout, no pulses
    reload();
    CARD_IN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen = seen | INVALID_SEL | FAILED_TRAN | VEND | (COST != 3'd0);
    end
    CARD_IN = 1'b0;
    step(7);
    check_eq("t6_no_activity", seen, 0);
    check_eq("t6_vend", VEND, 0);
    check_eq("t6_cost", COST, 0);

    // Machine still usable afterwards
    select(4'd0, 4'd4);
    check_eq("t7_code4_cost", COST, 2);
    VALID_TRAN = 1'b1;
    step(1);
    VALID_TRAN = 1'b0;
    check_eq("t7_vend", VEND, 1);
    check_eq("t7_slot4", dut.r_cnt[4], 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Card-operated vending machine controller: 20 item slots (codes 00–19), each holding up to 10 units.
- A two-digit selection is entered on a keypad. The block shows the item cost, waits for payment approval, vends, then supervises the delivery door.
- Sits between keypad/card-reader/payment front end and the dispensing mechanism. Inputs are synchronous to CLK.

Parameters:
- NUM_ITEMS, 20, number of item slots (codes 0..NUM_ITEMS-1)
- CAPACITY, 10, units per slot after RELOAD
- TIMEOUT, 5, clock cycles allowed for each user action

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset (0 = reset)
- RELOAD  in  1  refill all slots to CAPACITY; honoured only in IDLE
- CARD_IN  in  1  card inserted; starts a transaction from IDLE
- ITEM_CODE  in  4  one BCD keypad digit, sampled with a key press
- KEY_PRESS  in  1  keypad strobe; its rising edge (registered previous value) captures ITEM_CODE
- VALID_TRAN  in  1  payment approved
- DOOR_OPEN  in  1  delivery door open
- VEND  out  1  dispense/item available
- INVALID_SEL  out  1  one-cycle pulse: bad, timed-out or empty selection
- COST  out  3  price of selected item (1..6), 0 when no selection held
- FAILED_TRAN  out  1  one-cycle pulse: payment not approved in time

Behaviour:
- Reset (RST=0, async):
  - all 20 slot counters = 0 (machine empty); state = IDLE.
  - Outputs: VEND=0, INVALID_SEL=0, FAILED_TRAN=0, COST=0.
  - Timeout counter and digit registers cleared.
- Prices by code:
  - 0–3 → 1; 4–7 → 2; 8–11 → 3; 12–15 → 4; 16–17 → 5; 18–19 → 6.
- IDLE:
  - RELOAD=1 → every counter = CAPACITY; stay IDLE. RELOAD has priority over CARD_IN.
  - Else CARD_IN=1 → GET_D1.
  - RELOAD in any other state is ignored.
- Timeout counter:
  - Cleared on entry to each wait state (GET_D1, GET_D2, WAIT_PAY, WAIT_DOOR).
  - Timeout fires when the awaited event has not occurred by the TIMEOUT-th clock edge in that state.
- GET_D1:
  - Key edge → store digit d1 → GET_D2.
  - Timeout → IDLE silently (no pulse).
- GET_D2:
  - Key edge → store d2 → CHECK.
  - Timeout → INVALID_SEL pulse, → IDLE.
- CHECK (1 cycle):
  - code = d1*10+d2.
  - Invalid if d1>1, d2>9, code≥NUM_ITEMS, or that slot's counter = 0 → INVALID_SEL pulse, → IDLE.
  - Else COST = price(code) → WAIT_PAY.
- WAIT_PAY:
  - COST held.
  - VALID_TRAN=1 → VEND=1, decrement slot counter → WAIT_DOOR.
  - Timeout → FAILED_TRAN pulse, COST=0, → IDLE.
- WAIT_DOOR:
  - VEND held.
  - DOOR_OPEN=1 → DOOR_OPENED.
  - Timeout (door never opened) → VEND=0, COST=0, → IDLE; item stays counted as vended.
- DOOR_OPENED:
  - No timeout; wait for DOOR_OPEN=0 → VEND=0, COST=0, → IDLE.
- General:
  - CARD_IN level is irrelevant after the transaction starts; removing the card does not abort it.
  - INVALID_SEL and FAILED_TRAN are high for exactly one cycle and are never high together.
  - Counters saturate at 0; a decrement only happens on a valid vend.
  - Async reset mid-transaction aborts immediately to the reset state, including emptying all slots.

Test Plan:
- Reset, RELOAD pulse, CARD_IN, keys 1 then 6, VALID_TRAN, DOOR_OPEN pulse → COST=5 after 2nd digit; VEND=1 from VALID_TRAN until door closes; slot 16 count 10→9; back to IDLE.
- Same sequence but no DOOR_OPEN → VEND stays high 5 cycles, then 0; IDLE; slot 16 decremented.
- Keys 1,6 with no VALID_TRAN → COST=5 for 5 cycles, then one-cycle FAILED_TRAN, COST=0, no decrement.
- RST low pulse, release, then CARD_IN, keys 1,6 → INVALID_SEL pulse (slot empty after reset); VEND stays 0.
- After RELOAD, keys 2 then 6 → INVALID_SEL pulse. Also: key 2 pressed, then no second key → INVALID_SEL pulse after 5 cycles.
- After RELOAD, CARD_IN held with no key press → returns to IDLE after 5 cycles with all outputs 0 and no pulses.
